// File: rtl/cg_rvarch_pkg.sv
// Shared types for the RV32 immediate decode stage: immediate formats,
// RV32 base opcodes, buffered entry layout and skid-buffer states.
package cg_rvarch_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
        logic [XLEN-1:0] target;
    } imm_stage_entry_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/cg_rvarch_imm_select.sv
// Combinational RV32 opcode classifier and immediate extractor.
// Unrecognised opcodes (including compressed encodings) report illegal with a zero immediate.
module cg_rvarch_imm_select
    import cg_rvarch_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    // Classify the opcode into the immediate format it carries.
    always_comb begin
        fmt     = IMM_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
            OPC_STORE:             fmt = IMM_S;
            OPC_BRANCH:            fmt = IMM_B;
            OPC_AUIPC, OPC_LUI:    fmt = IMM_U;
            OPC_JAL:               fmt = IMM_J;
            OPC_OP:                fmt = IMM_NONE;
            default:               illegal = 1'b1;
        endcase
    end

    // Assemble and sign-extend the immediate for the selected format.
    always_comb begin
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/cg_rvarch_imm_decode_stage.sv
// RV32 immediate decode stage with a 2-entry skid buffer (main + skid register).
// Optional branch/jump target adder enabled by defining CG_IMM_TARGET_ADDER_EN;
// without it o_target is tied to zero and no target is stored.
//
// state      | meaning
// -----------+-----------------------------------------------
// SKID_EMPTY | no entry held, o_valid low
// SKID_ONE   | main register holds the head entry
// SKID_FULL  | main holds head, skid holds next; o_ready low
module cg_rvarch_imm_decode_stage
    import cg_rvarch_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [ADDR_WIDTH-1:0]  i_pc,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [DATA_WIDTH-1:0]  o_imm,
    output logic [2:0]             o_fmt,
    output logic                   o_illegal,
    output logic [DATA_WIDTH-1:0]  o_target
);

    skid_state_e      state_q, state_d;
    imm_stage_entry_t main_q, skid_q, cap;
    logic [XLEN-1:0]  sel_imm;
    imm_fmt_e         sel_fmt;
    logic             sel_illegal;
    logic             push, pop;
    logic             load_main_new, load_main_skid, load_skid;

    // Handshake is derived purely from the state flops, so o_ready has no
    // combinational dependence on i_valid or i_ready.
    assign o_ready = (state_q != SKID_FULL);
    assign o_valid = (state_q != SKID_EMPTY);
    assign push    = i_valid & o_ready;
    assign pop     = o_valid & i_ready;

    cg_rvarch_imm_select u_select (
        .instr   (i_instr),
        .imm     (sel_imm),
        .fmt     (sel_fmt),
        .illegal (sel_illegal)
    );

    // Build the entry captured on a push, including the optional target.
    always_comb begin
        cap.instr   = i_instr;
        cap.pc      = i_pc;
        cap.imm     = sel_imm;
        cap.fmt     = sel_fmt;
        cap.illegal = sel_illegal;
`ifdef CG_IMM_TARGET_ADDER_EN
        cap.target  = (sel_illegal || sel_fmt == IMM_NONE) ? '0 : i_pc + sel_imm;
`else
        cap.target  = '0;
`endif
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= SKID_EMPTY;
        else          state_q <= state_d;
    end

    // Next-state and register-load decisions; flush overrides push and pop.
    always_comb begin
        state_d        = state_q;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (i_flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        load_main_new = 1'b1;
                        state_d       = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        load_main_new = 1'b1;
                    end else if (push) begin
                        load_skid = 1'b1;
                        state_d   = SKID_FULL;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (pop) begin
                        load_main_skid = 1'b1;
                        state_d        = SKID_ONE;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // Entry storage; main only changes on a load, keeping outputs stable under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_new)       main_q <= cap;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= cap;
        end
    end

    assign o_instr   = main_q.instr;
    assign o_pc      = main_q.pc;
    assign o_imm     = main_q.imm;
    assign o_fmt     = main_q.fmt;
    assign o_illegal = main_q.illegal;
    assign o_target  = main_q.target;

endmodule

// File: tb/tb_cg_rvarch_imm_decode_stage.sv
module tb_cg_rvarch_imm_decode_stage;
    import cg_rvarch_pkg::*;

    logic        i_clk, i_rst_n, i_flush, i_valid, i_ready;
    logic        o_ready, o_valid, o_illegal;
    logic [31:0] i_instr, i_pc, o_instr, o_pc, o_imm, o_target;
    logic [2:0]  o_fmt;

    int errors = 0;
    int checks = 0;

    cg_rvarch_imm_decode_stage dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (i_flush),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_instr   (i_instr),
        .i_pc      (i_pc),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_instr   (o_instr),
        .o_pc      (o_pc),
        .o_imm     (o_imm),
        .o_fmt     (o_fmt),
        .o_illegal (o_illegal),
        .o_target  (o_target)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_target(input logic [31:0] t);
`ifdef CG_IMM_TARGET_ADDER_EN
        return t;
`else
        return 32'h0 & t;
`endif
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Push two entries with downstream stalled so the buffer ends FULL.
    task automatic fill_full(input logic [31:0] a, input logic [31:0] b);
        i_ready = 1'b0;
        i_valid = 1'b1; i_instr = a; i_pc = 32'h400;
        tick();
        i_instr = b; i_pc = 32'h404;
        tick();
        i_valid = 1'b0;
    endtask

    logic [31:0] exp_q[$];
    logic [31:0] exp_head;

    initial begin
        vecs[0]  = '{32'hFE000EE3, 32'h100,  32'hFFFFFFFC, IMM_B,    1'b0, 32'h000000FC};
        vecs[1]  = '{32'h123450B7, 32'h200,  32'h12345000, IMM_U,    1'b0, 32'h12345200};
        vecs[2]  = '{32'h00B50533, 32'h204,  32'h00000000, IMM_NONE, 1'b0, 32'h00000000};
        vecs[3]  = '{32'h0000007F, 32'h208,  32'h00000000, IMM_NONE, 1'b1, 32'h00000000};
        vecs[4]  = '{32'h00000001, 32'h20C,  32'h00000000, IMM_NONE, 1'b1, 32'h00000000};
        vecs[5]  = '{32'hFF9FF06F, 32'h1000, 32'hFFFFFFF8, IMM_J,    1'b0, 32'h00000FF8};
        vecs[6]  = '{32'hFFF00093, 32'h10,   32'hFFFFFFFF, IMM_I,    1'b0, 32'h0000000F};
        vecs[7]  = '{32'hFE512A23, 32'h20,   32'hFFFFFFF4, IMM_S,    1'b0, 32'h00000014};
        vecs[8]  = '{32'h00001017, 32'h300,  32'h00001000, IMM_U,    1'b0, 32'h00001300};
        vecs[9]  = '{32'h7FF00013, 32'h50,   32'h000007FF, IMM_I,    1'b0, 32'h0000084F};
        vecs[10] = '{32'h80002003, 32'h40,   32'hFFFFF800, IMM_I,    1'b0, 32'hFFFFF840};
        vecs[11] = '{32'h00000463, 32'h80,   32'h00000008, IMM_B,    1'b0, 32'h00000088};
        vecs[12] = '{32'h00000073, 32'h60,   32'h00000000, IMM_I,    1'b0, 32'h00000060};
        vecs[13] = '{32'h0000000F, 32'h70,   32'h00000000, IMM_I,    1'b0, 32'h00000070};
        vecs[14] = '{32'h0000005B, 32'h90,   32'h00000000, IMM_NONE, 1'b1, 32'h00000000};
        vecs[15] = '{32'h00000067, 32'hA0,   32'h00000000, IMM_I,    1'b0, 32'h000000A0};
        vecs[16] = '{32'hFFFFF037, 32'h10,   32'hFFFFF000, IMM_U,    1'b0, 32'hFFFFF010};

        i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_instr = '0;   i_pc = '0;
        repeat (2) tick();
        check("rst o_valid", {31'b0, o_valid}, 32'd0);
        check("rst o_ready", {31'b0, o_ready}, 32'd1);
        check("rst o_imm",   o_imm,            32'd0);
        check("rst o_fmt",   {29'b0, o_fmt},   {29'b0, IMM_NONE});
        check("rst o_instr", o_instr,          32'd0);
        check("rst o_target", o_target,        32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Single-entry transactions, one result the cycle after accept.
        for (int i = 0; i < 17; i++) begin
            i_ready = 1'b1;
            i_valid = 1'b1; i_instr = vecs[i].instr; i_pc = vecs[i].pc;
            tick();
            i_valid = 1'b0;
            check($sformatf("vec%0d valid", i),   {31'b0, o_valid},   32'd1);
            check($sformatf("vec%0d instr", i),   o_instr,            vecs[i].instr);
            check($sformatf("vec%0d pc", i),      o_pc,               vecs[i].pc);
            check($sformatf("vec%0d imm", i),     o_imm,              vecs[i].imm);
            check($sformatf("vec%0d fmt", i),     {29'b0, o_fmt},     {29'b0, vecs[i].fmt});
            check($sformatf("vec%0d illegal", i), {31'b0, o_illegal}, {31'b0, vecs[i].illegal});
            check($sformatf("vec%0d target", i),  o_target,           exp_target(vecs[i].tgt));
            tick();
            check($sformatf("vec%0d popped", i),  {31'b0, o_valid},   32'd0);
        end

        // Backpressure: A, B fill the buffer, C is held until space appears.
        fill_full(32'h00100093, 32'h00200113);
        check("full o_ready", {31'b0, o_ready}, 32'd0);
        check("full head",    o_instr,          32'h00100093);
        i_valid = 1'b1; i_instr = 32'h00300193; i_pc = 32'h408;
        tick();
        check("held o_ready", {31'b0, o_ready}, 32'd0);
        check("held head",    o_instr,          32'h00100093);
        check("held imm",     o_imm,            32'h00000001);
        exp_q = '{32'h00100093, 32'h00200113, 32'h00300193};
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic accepting;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain extra", {31'b0, o_valid}, 32'd0);
                end else begin
                    exp_head = exp_q.pop_front();
                    check("drain order", o_instr, exp_head);
                end
            end
            accepting = i_valid && o_ready;
            tick();
            if (accepting) i_valid = 1'b0;
            if (exp_q.size() == 0) break;
        end
        check("drain left", exp_q.size(), 32'd0);
        check("drain empty", {31'b0, o_valid}, 32'd0);

        // Flush while FULL with a simultaneous push: everything is dropped.
        fill_full(32'h00100093, 32'h00200113);
        check("preflush o_ready", {31'b0, o_ready}, 32'd0);
        i_flush = 1'b1; i_valid = 1'b1; i_instr = 32'h00300193; i_pc = 32'h408;
        tick();
        i_flush = 1'b0; i_valid = 1'b0;
        check("flush o_valid", {31'b0, o_valid}, 32'd0);
        check("flush o_ready", {31'b0, o_ready}, 32'd1);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("flush stale", {31'b0, o_valid}, 32'd0);
        end
        i_valid = 1'b1; i_instr = 32'hFFF00093; i_pc = 32'h500;
        tick();
        i_valid = 1'b0;
        check("postflush valid", {31'b0, o_valid}, 32'd1);
        check("postflush instr", o_instr, 32'hFFF00093);
        check("postflush imm",   o_imm,   32'hFFFFFFFF);
        tick();

        // Asynchronous reset while FULL drops all entries immediately.
        fill_full(32'h123450B7, 32'hFE000EE3);
        check("prerst o_valid", {31'b0, o_valid}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("midrst o_valid", {31'b0, o_valid}, 32'd0);
        check("midrst o_ready", {31'b0, o_ready}, 32'd1);
        check("midrst o_imm",   o_imm,            32'd0);
        check("midrst o_fmt",   {29'b0, o_fmt},   {29'b0, IMM_NONE});
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick();
        check("postrst o_valid", {31'b0, o_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
